// File: rtl/phase_timer_pkg.sv
// phase_timer_pkg: light codes and timer width shared with the traffic-light FSM
package phase_timer_pkg;
    localparam int TIMER_W = 4;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b111;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;
    function automatic logic legal_light(input logic [2:0] l);
        return l == LIGHT_RED || l == LIGHT_GREEN || l == LIGHT_YELLOW;
    endfunction
endpackage

// File: rtl/phase_timer_tick_prescaler.sv
// phase_timer_tick_prescaler: clock-enable divider with hold gating and clear
module phase_timer_tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic clr,
    output logic tick
);
    logic [15:0] count;
    logic        wrap;
    assign wrap = count == 16'(PRESCALE - 1);
    assign tick = !rst && !hold && wrap;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr || (!hold && wrap)) count <= '0;
        else if (!hold) count <= count + 16'd1;
endmodule

// File: rtl/phase_timer.sv
// phase_timer: prescaled phase countdown feeding the traffic-light FSM, reloaded per light code
// Optional pedestrian green truncation enabled by PHASE_TIMER_PED_EN.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int PRESCALE      = 4,
    parameter int RED_TIME      = 8,
    parameter int GREEN_TIME    = 6,
    parameter int YELLOW_TIME   = 2,
    parameter int PED_GREEN_MIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [2:0]         light,
`ifdef PHASE_TIMER_PED_EN
    input  logic               ped_req,
`endif
    output logic [TIMER_W-1:0] timer,
    output logic               tick,
    output logic               fault
);
    if (PRESCALE < 1 || PRESCALE > 65535 || RED_TIME < 1 || RED_TIME > 15 ||
        GREEN_TIME < 1 || GREEN_TIME > 15 || YELLOW_TIME < 1 || YELLOW_TIME > 15 ||
        PED_GREEN_MIN < 1 || PED_GREEN_MIN > GREEN_TIME) begin : g_param_check
        $error("phase_timer: parameter out of range");
    end
    logic               reload;
    logic               trunc;
    logic [TIMER_W-1:0] reload_val;
    logic [TIMER_W-1:0] timer_d;
    assign reload = timer == '0;
    // reload picks the duration of the phase the FSM is about to enter
    assign reload_val = light == LIGHT_RED   ? TIMER_W'(GREEN_TIME)  :
                        light == LIGHT_GREEN ? TIMER_W'(YELLOW_TIME) : TIMER_W'(RED_TIME);
`ifdef PHASE_TIMER_PED_EN
    logic ped_pending;
    assign trunc = light == LIGHT_GREEN && (ped_pending || ped_req) && timer > TIMER_W'(PED_GREEN_MIN);
    always_ff @(posedge clk or posedge rst)
        if (rst) ped_pending <= 1'b0;
        else ped_pending <= !trunc && (ped_req || (ped_pending && !(reload && light == LIGHT_GREEN)));
`else
    assign trunc = 1'b0;
`endif
    assign timer_d = reload ? reload_val :
                     trunc  ? TIMER_W'(PED_GREEN_MIN) :
                     tick   ? timer - 1'b1 : timer;
    phase_timer_tick_prescaler #(.PRESCALE(PRESCALE)) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .clr  (reload),
        .tick (tick)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            timer <= TIMER_W'(RED_TIME);
            fault <= 1'b0;
        end else begin
            timer <= timer_d;
            if (reload && !legal_light(light)) fault <= 1'b1;
        end
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: vector table plus closed-loop FSM sequences for phase_timer
module tb_phase_timer;
    import phase_timer_pkg::*;

    typedef struct {
        logic       hold;
        logic [2:0] light;
        int         t;
        int         tk;
        int         f;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       hold;
    logic [2:0] light;
    logic [2:0] drv_light;
    logic [2:0] fsm_light;
    logic       fsm_en;
    logic [3:0] timer;
    logic       tick;
    logic       fault;
`ifdef PHASE_TIMER_PED_EN
    logic       ped_req;
`endif

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    assign light = fsm_en ? fsm_light : drv_light;

    phase_timer #(
        .PRESCALE(2), .RED_TIME(3), .GREEN_TIME(4), .YELLOW_TIME(2), .PED_GREEN_MIN(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .light (light),
`ifdef PHASE_TIMER_PED_EN
        .ped_req (ped_req),
`endif
        .timer (timer),
        .tick  (tick),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] nxt(input logic [2:0] l);
        return l == LIGHT_RED ? LIGHT_GREEN : l == LIGHT_GREEN ? LIGHT_YELLOW : LIGHT_RED;
    endfunction

    // behavioural FSM: advances on the edge where timer is zero
    always @(posedge clk or posedge rst)
        if (rst) fsm_light <= LIGHT_RED;
        else if (timer == 4'd0) fsm_light <= nxt(fsm_light);

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic h, input logic [2:0] l, input int t, input int tk, input int f);
        vec_t v;
        v.hold = h; v.light = l; v.t = t; v.tk = tk; v.f = f;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cur_len, zeros, ph, c;
        int exp_len[3] = '{7, 9, 5};
        logic [2:0] cur;
        bit found;
        rst = 1'b1; hold = 1'b0; drv_light = LIGHT_RED; fsm_en = 1'b0;
`ifdef PHASE_TIMER_PED_EN
        ped_req = 1'b0;
`endif
        // red countdown, green with hold, hold at zero, yellow, illegal code, sticky fault
        add(0, 3'b100, 3, 0, 0); add(0, 3'b100, 3, 1, 0); add(0, 3'b100, 2, 0, 0);
        add(0, 3'b100, 2, 1, 0); add(0, 3'b100, 1, 0, 0); add(0, 3'b100, 1, 1, 0);
        add(0, 3'b100, 0, 0, 0); add(0, 3'b111, 4, 0, 0); add(0, 3'b111, 4, 1, 0);
        add(0, 3'b111, 3, 0, 0); add(0, 3'b111, 3, 1, 0); add(0, 3'b111, 2, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 3'b111, 2, 0, 0);
        add(0, 3'b111, 2, 1, 0); add(0, 3'b111, 1, 0, 0); add(0, 3'b111, 1, 1, 0);
        add(1, 3'b111, 0, 0, 0); add(0, 3'b001, 2, 0, 0); add(0, 3'b001, 2, 1, 0);
        add(0, 3'b001, 1, 0, 0); add(0, 3'b001, 1, 1, 0); add(0, 3'b000, 0, 0, 0);
        add(0, 3'b100, 3, 0, 1); add(0, 3'b100, 3, 1, 1); add(0, 3'b100, 2, 0, 1);
        add(0, 3'b100, 2, 1, 1); add(0, 3'b100, 1, 0, 1); add(0, 3'b100, 1, 1, 1);
        add(0, 3'b100, 0, 0, 1); add(0, 3'b111, 4, 0, 1);
        step();
        rst = 1'b0;
        foreach (tbl[i]) begin
            hold = tbl[i].hold;
            drv_light = tbl[i].light;
            #1;
            check(int'(timer) == tbl[i].t && int'(tick) == tbl[i].tk && int'(fault) == tbl[i].f,
                  $sformatf("vec%0d {timer,tick,fault}x100", i),
                  int'(timer) * 100 + int'(tick) * 10 + int'(fault),
                  tbl[i].t * 100 + tbl[i].tk * 10 + tbl[i].f);
            step();
        end
        hold = 1'b0;
        drv_light = LIGHT_GREEN;
        found = 1'b0;
        for (c = 0; c < 20; c++) begin
            if (timer == 4'd1) begin found = 1'b1; break; end
            step();
        end
        if (!found) check(1'b0, "wait_timer1", c, 20);
        #2;
        rst = 1'b1;
        #1;
        check(timer == 4'd3 && !tick && !fault, "async_reset {timer,tick,fault}x100",
              int'(timer) * 100 + int'(tick) * 10 + int'(fault), 300);
        fsm_en = 1'b1;
        step();
        rst = 1'b0;
        cur = fsm_light; cur_len = 0; zeros = 0; ph = 0;
        for (c = 0; c < 100 && ph < 3; c++) begin
            cur_len++;
            if (timer == 4'd0) zeros++;
            step();
            if (fsm_light != cur) begin
                check(cur_len == exp_len[ph], $sformatf("phase%0d_len", ph), cur_len, exp_len[ph]);
                check(zeros == 1, $sformatf("phase%0d_zeros", ph), zeros, 1);
                check(fsm_light == nxt(cur), $sformatf("phase%0d_next", ph), int'(fsm_light), int'(nxt(cur)));
                check(!fault, $sformatf("phase%0d_fault", ph), int'(fault), 0);
                ph++; cur = fsm_light; cur_len = 0; zeros = 0;
            end
        end
        if (ph < 3) check(1'b0, "closed_loop_timeout", ph, 3);
`ifdef PHASE_TIMER_PED_EN
        found = 1'b0;
        for (c = 0; c < 30; c++) begin
            if (fsm_light == LIGHT_GREEN) begin found = 1'b1; break; end
            step();
        end
        if (!found) check(1'b0, "wait_green1", c, 30);
        check(timer == 4'd4, "ped_green_start", int'(timer), 4);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check(timer == 4'd2, "ped_trunc", int'(timer), 2);
        step();
        check(timer == 4'd1, "ped_after_trunc", int'(timer), 1);
        step();
        step();
        check(timer == 4'd0, "ped_zero", int'(timer), 0);
        step();
        check(timer == 4'd2 && fsm_light == LIGHT_YELLOW, "ped_yellow_reload", int'(timer), 2);
        found = 1'b0;
        for (c = 0; c < 30; c++) begin
            if (fsm_light == LIGHT_RED) begin found = 1'b1; break; end
            step();
        end
        if (!found) check(1'b0, "wait_red", c, 30);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check(timer == 4'd3, "ped_red_untouched", int'(timer), 3);
        found = 1'b0;
        for (c = 0; c < 30; c++) begin
            if (fsm_light == LIGHT_GREEN) begin found = 1'b1; break; end
            step();
        end
        if (!found) check(1'b0, "wait_green2", c, 30);
        check(timer == 4'd4, "ped_pending_green_start", int'(timer), 4);
        step();
        check(timer == 4'd2, "ped_pending_trunc", int'(timer), 2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Upstream companion of the traffic-light FSM.
- Generates the 4-bit countdown `timer` the FSM consumes. The FSM advances phase on the clk edge where `timer == 0`.
- Watches the FSM's `light` code and reloads the duration of the phase that follows.
- Includes a clock-enable prescaler, a hold input and a sticky fault flag for illegal light codes.

Parameters:
- PRESCALE, 4, clk cycles per timer tick; legal range 1..65535; 1 means a tick every cycle.
- RED_TIME, 8, ticks loaded for the red phase; legal range 1..15.
- GREEN_TIME, 6, ticks loaded for the green phase; legal range 1..15.
- YELLOW_TIME, 2, ticks loaded for the yellow phase; legal range 1..15.
- PED_GREEN_MIN, 2, green truncation target; legal range 1..GREEN_TIME; used only with PHASE_TIMER_PED_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- hold  in  1  freezes prescaler and countdown
- light  in  3  current light code from FSM: 100 red, 111 green, 001 yellow
- ped_req  in  1  pedestrian request pulse/level; present only with PHASE_TIMER_PED_EN
- timer  out  4  countdown to FSM
- tick  out  1  one-clk pulse at each prescaled tick
- fault  out  1  sticky illegal-light flag

Behaviour:
- Reset (async) values: timer=RED_TIME, prescaler count=0, tick=0, fault=0. This matches the FSM's red reset state.
- Prescaler:
  - Counts 0..PRESCALE-1 while hold=0.
  - tick=1 for the one clk where count==PRESCALE-1; count then wraps to 0.
  - Count is forced to 0 on every reload edge, so each phase starts with a full prescale period.
- Countdown:
  - When timer>0 and tick=1, timer decrements by 1 at the next edge. No other decrement source.
- Zero / reload:
  - When timer==0, the next clk edge unconditionally reloads timer. This is the same edge where the FSM changes phase.
  - Reload value is selected from the light code sampled before that edge:
    - 100 → GREEN_TIME
    - 111 → YELLOW_TIME
    - 001 → RED_TIME
    - any other code → RED_TIME, and fault is set.
  - timer is therefore 0 for exactly one clk per phase.
  - Phase length = D×PRESCALE + 1 clk cycles.
- Hold:
  - hold=1 freezes the prescaler count and suppresses tick and decrement.
  - Reload at timer==0 still occurs regardless of hold, because the FSM advances unconditionally on zero.
- fault:
  - Set only at a reload edge with an illegal light code.
  - Cleared only by rst.
  - Does not otherwise alter behaviour.
- Simultaneous events:
  - Reload takes priority over tick.
  - A tick coinciding with the zero cycle is consumed by the reload.
- Reset mid-phase: everything returns to reset values immediately and asynchronously.
- Width rule: timer never underflows; decrement is gated by timer>0.
- Elaboration check: parameters out of range cause elaboration to fail.

Optional Feature:
Macro PHASE_TIMER_PED_EN.
- With it defined:
  - ped_req port exists.
  - A request is latched into an internal ped_pending flag on any clk where ped_req=1.
  - While light==111 and ped_pending=1 and timer>PED_GREEN_MIN, timer is loaded with PED_GREEN_MIN at the next edge. This takes priority over decrement.
  - ped_pending clears on that truncation or on the reload out of green.
  - Requests in red or yellow stay pending until the next green.
  - rst clears ped_pending.
- Without it: no ped_req port, no ped_pending register, and green always runs the full GREEN_TIME.

Decomposition:
- Shared package holds:
  - Light code constants LIGHT_RED=3'b100, LIGHT_GREEN=3'b111, LIGHT_YELLOW=3'b001.
  - TIMER_W=4.
  - The FSM uses the same package.
- One natural sub-module: tick_prescaler. It holds the counter and hold gating, takes a clear input and outputs tick.

Test Plan:
Conditions: PRESCALE=2, RED=3, GREEN=4, YELLOW=2 unless stated.
- Reset: assert rst mid-count with timer=1 → timer=3, tick=0, fault=0 immediately, before the next clk.
- Red countdown with light=100 held: timer steps 3,2,1,0 every 2 clks; 0 lasts 1 clk; then timer=4. Check tick period = 2 clks.
- Closed loop with a behavioural FSM model:
  - Sequence red(3)→green(4)→yellow(2)→red.
  - Phase lengths 7, 9, 5 clks.
  - timer==0 exactly once per phase; no skipped phase.
- Hold: hold=1 for 5 clks at timer=2 → timer stays 2 and no tick; resume → continues at 2. Separately, hold=1 at timer==0 → reload still happens.
- Fault: light=000 at the zero cycle → reload 3, fault=1; fault stays 1 through later legal phases until rst.
- PED (macro on, PED_GREEN_MIN=2): ped_req pulse during green at timer=4 → timer=2 next edge, then 1, 0 → YELLOW_TIME. Second: pulse in red → truncation takes effect in the following green.
